// File: rtl/usb_tx_bit_sequencer.sv
// usb_tx_bit_sequencer
// Transmit bit sequencer for the USB full-speed encoder: serialises SYNC,
// data bytes (LSB first) and EOP, inserts stuff bits on request from the
// external stuff bit detector and NRZI-encodes the stream onto D+/D-.
// Optional feature: define TX_ABORT_EN to add the tx_abort input.
module usb_tx_bit_sequencer #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned TIMER_W      = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       bit_stuff,
`ifdef TX_ABORT_EN
  input  logic       tx_abort,
`endif
  output logic       shift_enable,
  output logic       d_orig,
  output logic       d_plus,
  output logic       d_minus,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP,
    S_EOP_J
  } state_t;

  localparam logic [TIMER_W-1:0] T_LAST = TIMER_W'(CLKS_PER_BIT - 1);

  state_t             state;
  state_t             nxt_state;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         bit_cnt;
  logic [2:0]         nxt_cnt;
  logic [2:0]         cnt_inc;
  logic [7:0]         hold;
  logic               hold_last;
  logic               err_seen;
  logic               line_j;
  logic               new_j;
  logic               nxt_raw;
  logic               do_load;
  logic               err_p;
  logic               fetch;
  logic               boundary;
  logic               step;
  logic               abort_req;

`ifdef TX_ABORT_EN
  assign abort_req = tx_abort;
`else
  assign abort_req = 1'b0;
`endif

  assign boundary = (timer == T_LAST);
  assign cnt_inc  = bit_cnt + 3'd1;
  // IDLE reacts to tx_start immediately; every other state only moves at a bit boundary.
  assign step     = (state == S_IDLE) ? tx_start : boundary;
  // NRZI: a raw 0 flips the J/K state, a raw 1 holds it.
  assign new_j    = nxt_raw ? line_j : ~line_j;
  assign tx_ready = fetch;

  // Next-bit decision; only acted on when step is high
  always_comb begin
    nxt_state = state;
    nxt_cnt   = bit_cnt;
    nxt_raw   = 1'b0;
    do_load   = 1'b0;
    err_p     = 1'b0;
    fetch     = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_start) begin
          nxt_state = S_SYNC;
          nxt_cnt   = '0;
        end
      end
      S_SYNC: begin
        if (boundary) begin
          if (abort_req) begin
            nxt_state = S_EOP;
            nxt_cnt   = '0;
            err_p     = 1'b1;
          end else if (bit_cnt == 3'd7) begin
            fetch = 1'b1;
          end else begin
            nxt_cnt = cnt_inc;
            nxt_raw = (cnt_inc == 3'd7);
          end
        end
      end
      S_DATA: begin
        if (boundary) begin
          if (abort_req) begin
            nxt_state = S_EOP;
            nxt_cnt   = '0;
            err_p     = 1'b1;
          end else if (bit_stuff) begin
            // bit_cnt stays on the bit just sent; STUFF advances past it.
            nxt_state = S_STUFF;
          end else if (bit_cnt == 3'd7) begin
            if (hold_last) begin
              nxt_state = S_EOP;
              nxt_cnt   = '0;
            end else begin
              fetch = 1'b1;
            end
          end else begin
            nxt_cnt = cnt_inc;
            nxt_raw = hold[cnt_inc];
          end
        end
      end
      S_STUFF: begin
        if (boundary) begin
          if (abort_req) begin
            nxt_state = S_EOP;
            nxt_cnt   = '0;
            err_p     = 1'b1;
          end else if (bit_cnt == 3'd7) begin
            if (hold_last) begin
              nxt_state = S_EOP;
              nxt_cnt   = '0;
            end else begin
              fetch = 1'b1;
            end
          end else begin
            nxt_state = S_DATA;
            nxt_cnt   = cnt_inc;
            nxt_raw   = hold[cnt_inc];
          end
        end
      end
      S_EOP: begin
        if (boundary) begin
          if (bit_cnt == 3'd1) begin
            nxt_state = S_EOP_J;
          end else begin
            nxt_cnt = cnt_inc;
          end
        end
      end
      S_EOP_J: begin
        if (boundary) begin
          nxt_state = S_IDLE;
          nxt_cnt   = '0;
        end
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase
    // A byte fetch either loads the next byte or ends the packet as an underrun.
    if (fetch) begin
      nxt_cnt = '0;
      if (tx_valid) begin
        nxt_state = S_DATA;
        nxt_raw   = tx_data[0];
        do_load   = 1'b1;
      end else begin
        nxt_state = S_EOP;
        err_p     = 1'b1;
      end
    end
  end

  // Registered state, bit timer, line drive and handshake pulses
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      bit_cnt      <= '0;
      hold         <= '0;
      hold_last    <= 1'b0;
      err_seen     <= 1'b0;
      line_j       <= 1'b1;
      d_plus       <= 1'b1;
      d_minus      <= 1'b0;
      d_orig       <= 1'b0;
      shift_enable <= 1'b0;
      busy         <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
    end else begin
      shift_enable <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= err_p;
      if (state != S_IDLE) begin
        timer <= boundary ? '0 : timer + 1'b1;
      end
      if (step) begin
        state   <= nxt_state;
        bit_cnt <= nxt_cnt;
        if (do_load) begin
          hold      <= tx_data;
          hold_last <= tx_last;
        end
        if (state == S_IDLE) begin
          busy     <= 1'b1;
          err_seen <= 1'b0;
        end else begin
          err_seen <= err_seen | err_p;
        end
        case (nxt_state)
          S_SYNC, S_DATA, S_STUFF: begin
            d_orig       <= nxt_raw;
            shift_enable <= 1'b1;
            line_j       <= new_j;
            d_plus       <= new_j;
            d_minus      <= ~new_j;
          end
          S_EOP: begin
            d_orig  <= 1'b0;
            d_plus  <= 1'b0;
            d_minus <= 1'b0;
          end
          S_EOP_J: begin
            line_j  <= 1'b1;
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
          end
          default: begin
            busy    <= 1'b0;
            tx_done <= ~err_seen;
          end
        endcase
      end
    end
  end

endmodule
